// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

    // Frame sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4
    } state_t;

    // load_err codes
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_CHK     = 2'b11;

    // Default frame start marker
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_prog_loader_byte_timeout.sv
// Inter-byte watchdog: counts idle clocks while a frame is open and
// flags expiry when TIMEOUT_CLKS clocks pass without a byte.
module byte_timeout #(
    parameter int TIMEOUT_CLKS = 200_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic expire
);

    localparam int CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // Idle counter: held at zero outside a frame and on every received byte
    always_ff @(posedge clk) begin
        if (reset || !en || restart) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + ONE;
        end
    end

    // A byte arriving on the expiry cycle takes priority over the timeout
    assign expire = en && !restart && (cnt == LAST);

endmodule

// File: rtl/uart_prog_loader.sv
// Sequences the UART byte stream into a framed, checksum-verified program
// download into instruction memory and gates the processor run enable.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int          ADDR_W       = 10,
    parameter int          TIMEOUT_CLKS = 200_000,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              load_busy,
    output logic              load_done,
    output logic [1:0]        load_err,
    output logic              cpu_run
);

    localparam logic [16:0]   MAX_LEN  = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W + 1)'(1);

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      len_hi;
    logic [15:0]     len;
    logic [15:0]     len_in;
    logic [ADDR_W:0] addr_cnt;
    logic [16:0]     addr_nxt_ext;
    logic [1:0]      idx;
    logic [23:0]     word_p0;
    logic [7:0]      chk_acc;
    logic            vld_p1;
    logic            expire;
    logic            sync_hit;
    logic            len_bad;
    logic            last_word;
    logic            byte_in;

    // Word count must be non-zero and fit the instruction memory
    function automatic logic len_invalid(input logic [15:0] n);
        return (n == 16'd0) || ({1'b0, n} > MAX_LEN);
    endfunction

    assign sync_hit     = (state == IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    assign len_in       = {len_hi, rx_data};
    assign len_bad      = len_invalid(len_in);
    assign byte_in      = (state == DATA) && rx_valid;
    assign addr_nxt_ext = 17'(addr_cnt) + 17'd1;
    assign last_word    = (addr_nxt_ext == {1'b0, len});

    assign load_busy = (state != IDLE);
    assign mem_we    = vld_p1;

    byte_timeout #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .en      (load_busy),
        .restart (rx_valid),
        .expire  (expire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a timeout always returns to IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sync_hit) state_nxt = LEN_HI;
            LEN_HI:  if (rx_valid) state_nxt = LEN_LO;
            LEN_LO:  if (rx_valid) state_nxt = len_bad ? IDLE : DATA;
            DATA:    if (byte_in && (idx == 2'd3) && last_word) state_nxt = CHK;
            CHK:     if (rx_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (expire) begin
            state_nxt = IDLE;
        end
    end

    // Control and write port: counters, status flags and the memory write stage
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi    <= '0;
            len       <= '0;
            addr_cnt  <= '0;
            idx       <= '0;
            vld_p1    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            load_done <= 1'b0;
            load_err  <= ERR_NONE;
            cpu_run   <= 1'b0;
        end else begin
            vld_p1    <= 1'b0;
            load_done <= 1'b0;
            if (expire) begin
                load_err <= ERR_TIMEOUT;
                idx      <= '0;
            end
            unique case (state)
                IDLE: begin
                    if (sync_hit) begin
                        load_err <= ERR_NONE;
                        cpu_run  <= 1'b0;
                    end
                end
                LEN_HI: begin
                    if (rx_valid) len_hi <= rx_data;
                end
                LEN_LO: begin
                    if (rx_valid) begin
                        len      <= len_in;
                        addr_cnt <= '0;
                        idx      <= '0;
                        if (len_bad) load_err <= ERR_LEN;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            // ---- write stage p1: word complete, present to memory next cycle
                            vld_p1    <= 1'b1;
                            mem_addr  <= addr_cnt[ADDR_W-1:0];
                            mem_wdata <= {rx_data, word_p0};
                            addr_cnt  <= addr_cnt + ADDR_ONE;
                        end
                    end
                end
                CHK: begin
                    if (rx_valid) begin
                        if (rx_data == chk_acc) begin
                            load_done <= 1'b1;
                            cpu_run   <= 1'b1;
                        end else begin
                            load_err  <= ERR_CHK;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload datapath: low three bytes of the word and running XOR checksum
    always_ff @(posedge clk) begin
        if ((state == LEN_LO) && rx_valid) begin
            chk_acc <= '0;
        end else if (byte_in) begin
            chk_acc <= chk_acc ^ rx_data;
            case (idx)
                2'd0:    word_p0[7:0]   <= rx_data;
                2'd1:    word_p0[15:8]  <= rx_data;
                2'd2:    word_p0[23:16] <= rx_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: expected memory writes are queued
// as bytes are driven and popped when the DUT strobes mem_we.
module tb_uart_prog_loader;

    localparam int ADDR_W       = 10;
    localparam int TIMEOUT_CLKS = 40;
    localparam int GAP          = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              load_busy;
    logic              load_done;
    logic [1:0]        load_err;
    logic              cpu_run;

    wr_t         exp_q[$];
    logic [31:0] words_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;

    uart_prog_loader #(
        .ADDR_W       (ADDR_W),
        .TIMEOUT_CLKS (TIMEOUT_CLKS),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err),
        .cpu_run   (cpu_run)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every mem_we must match the head of the scoreboard
    always @(negedge clk) begin
        if (load_done) done_cnt++;
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_we", mem_we, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_val("wr_addr", mem_addr, e.addr);
                check_val("wr_data", mem_wdata, e.data);
            end
        end
    end

    // One byte strobe; checks write latency and done pulse on the following cycle
    task automatic send_byte(input logic [7:0] b, input bit exp_we, input bit exp_done);
        @(posedge clk) #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk) #1;
        rx_valid = 1'b0;
        @(negedge clk);
        check_val("we_latency", mem_we, exp_we);
        check_val("done_timing", load_done, exp_done);
        repeat (GAP) @(posedge clk);
    endtask

    task automatic send_frame(input logic [15:0] n, input logic [7:0] chk_flip, input bit exp_ok);
        logic [7:0] chk;
        logic [7:0] by;
        wr_t        e;
        chk = 8'h00;
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(n[15:8], 1'b0, 1'b0);
        send_byte(n[7:0], 1'b0, 1'b0);
        for (int w = 0; w < int'(n); w++) begin
            for (int b = 0; b < 4; b++) begin
                by  = words_q[w][8*b +: 8];
                chk = chk ^ by;
                if (b == 3) begin
                    e.addr = ADDR_W'(w);
                    e.data = words_q[w];
                    exp_q.push_back(e);
                end
                send_byte(by, b == 3, 1'b0);
            end
        end
        send_byte(chk ^ chk_flip, 1'b0, exp_ok);
    endtask

    task automatic expect_state(input string tag, input logic [1:0] err, input bit run,
                                input int done_delta, input int done_before);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val({tag, "_busy"}, load_busy, 1'b0);
        check_val({tag, "_err"}, load_err, err);
        check_val({tag, "_run"}, cpu_run, run);
        check_val({tag, "_done_cnt"}, done_cnt - done_before, done_delta);
        check_val({tag, "_pending_wr"}, exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_we", mem_we, 1'b0);
        check_val("rst_addr", mem_addr, '0);
        check_val("rst_wdata", mem_wdata, 32'h0);
        check_val("rst_busy", load_busy, 1'b0);
        check_val("rst_done", load_done, 1'b0);
        check_val("rst_err", load_err, 2'b00);
        check_val("rst_run", cpu_run, 1'b0);
        @(posedge clk) #1;
        reset = 1'b0;

        // Non-SYNC noise in IDLE is ignored
        send_byte(8'h3C, 1'b0, 1'b0);
        d0 = done_cnt;
        expect_state("noise", 2'b00, 1'b0, 0, d0);

        // Single-word frame
        words_q = '{32'h12345678};
        d0 = done_cnt;
        send_frame(16'd1, 8'h00, 1'b1);
        expect_state("single", 2'b00, 1'b1, 1, d0);

        // Two-word frame
        words_q = '{32'd1, 32'd2};
        d0 = done_cnt;
        send_frame(16'd2, 8'h00, 1'b1);
        expect_state("two_word", 2'b00, 1'b1, 1, d0);

        // Bad checksum: word still written, no run
        words_q = '{32'h12345678};
        d0 = done_cnt;
        send_frame(16'd1, 8'h01, 1'b0);
        expect_state("bad_chk", 2'b11, 1'b0, 0, d0);

        // Zero length
        d0 = done_cnt;
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        expect_state("len_zero", 2'b10, 1'b0, 0, d0);

        // Length one past capacity
        d0 = done_cnt;
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h04, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        expect_state("len_big", 2'b10, 1'b0, 0, d0);

        // Timeout mid-word, then a normal frame
        d0 = done_cnt;
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h78, 1'b0, 1'b0);
        send_byte(8'h56, 1'b0, 1'b0);
        repeat (TIMEOUT_CLKS / 2) @(posedge clk);
        @(negedge clk);
        check_val("pre_timeout_busy", load_busy, 1'b1);
        check_val("pre_timeout_err", load_err, 2'b00);
        repeat (TIMEOUT_CLKS) @(posedge clk);
        expect_state("timeout", 2'b01, 1'b0, 0, d0);
        words_q = '{32'hCAFEF00D};
        d0 = done_cnt;
        send_frame(16'd1, 8'h00, 1'b1);
        expect_state("after_timeout", 2'b00, 1'b1, 1, d0);

        // Reset in the middle of a word
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        @(posedge clk) #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("mid_rst_busy", load_busy, 1'b0);
        check_val("mid_rst_run", cpu_run, 1'b0);
        check_val("mid_rst_err", load_err, 2'b00);
        check_val("mid_rst_we", mem_we, 1'b0);
        check_val("mid_rst_addr", mem_addr, '0);
        check_val("mid_rst_wdata", mem_wdata, 32'h0);
        @(posedge clk) #1;
        reset = 1'b0;
        words_q = '{32'h12345678};
        d0 = done_cnt;
        send_frame(16'd1, 8'h00, 1'b1);
        expect_state("post_rst", 2'b00, 1'b1, 1, d0);

        // Full-capacity frame; SYNC value appears as payload in word 0
        words_q.delete();
        for (int i = 0; i < (2 ** ADDR_W); i++) begin
            if (i == 0) words_q.push_back(32'h000000A5);
            else        words_q.push_back({16'(i), ~16'(i)});
        end
        d0 = done_cnt;
        send_frame(16'(2 ** ADDR_W), 8'h00, 1'b1);
        expect_state("full", 2'b00, 1'b1, 1, d0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
